// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: FSM states and EXE forwarding
// select codes.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_RUN   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   localparam logic [1:0] FWD_REG     = 2'd0;
   localparam logic [1:0] FWD_ALU_MEM = 2'd1;
   localparam logic [1:0] FWD_MEM_DIN = 2'd2;
   localparam logic [1:0] FWD_WB      = 2'd3;

endpackage

// File: rtl/pipe_ctrl_fwd_unit.sv
// Forwarding select for one EXE source operand; the MEM stage beats WB and
// register $0 is never forwarded.
module fwd_unit
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] i_src_addr,
   input  logic       i_wb_wen_mem,
   input  logic       i_mem_ren_mem,
   input  logic [4:0] i_regw_addr_mem,
   input  logic       i_wb_wen_wb,
   input  logic [4:0] i_regw_addr_wb,
   output logic [1:0] o_fwd_ctrl
);

   logic w_hitMem;
   logic w_hitWb;

   assign w_hitMem = i_wb_wen_mem && (i_regw_addr_mem == i_src_addr) && (i_regw_addr_mem != 5'd0);
   assign w_hitWb  = i_wb_wen_wb  && (i_regw_addr_wb  == i_src_addr) && (i_regw_addr_wb  != 5'd0);

   // A load in MEM supplies its value through mem_din, so load-use never stalls.
   always_comb begin
      o_fwd_ctrl = FWD_REG;
      if (w_hitMem)
         o_fwd_ctrl = i_mem_ren_mem ? FWD_MEM_DIN : FWD_ALU_MEM;
      else if (w_hitWb)
         o_fwd_ctrl = FWD_WB;
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: reset release, branch flush, data-memory wait states with
// timeout, debug halt/single-step, plus EXE operand forwarding selects.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int RST_CYCLES  = 2,
   parameter int MEM_TIMEOUT = 16
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       is_branch_exe,
   input  logic       is_branch_mem,
   input  logic [4:0] addr_rs_exe,
   input  logic [4:0] addr_rt_exe,
   input  logic       wb_wen_mem,
   input  logic       mem_ren_mem,
   input  logic       mem_wen_mem,
   input  logic [4:0] regw_addr_mem,
   input  logic       wb_wen_wb,
   input  logic [4:0] regw_addr_wb,
   input  logic       mem_ack,
   input  logic       debug_en,
   input  logic       debug_step,
   output logic       if_rst,
   output logic       id_rst,
   output logic       exe_rst,
   output logic       mem_rst,
   output logic       wb_rst,
   output logic       if_en,
   output logic       id_en,
   output logic       exe_en,
   output logic       mem_en,
   output logic       wb_en,
   output logic [1:0] exe_fwd_a_ctrl,
   output logic [1:0] exe_fwd_b_ctrl,
   output logic       mem_err,
   output logic [1:0] state_dbg
);

   state_t     r_state;
   state_t     w_nextState;
   logic [7:0] r_cnt;
   logic       r_memErr;
   logic       r_stepPrev;

   logic       w_stall;
   logic       w_stepRise;
   logic       w_timeoutHit;
   logic       w_waitDone;
   logic       w_advance;
   logic [4:0] w_rstVec;
   logic [4:0] w_enVec;

   assign w_stall      = (mem_ren_mem || mem_wen_mem) && !mem_ack;
   assign w_stepRise   = debug_step && !r_stepPrev;
   assign w_timeoutHit = (r_cnt == 8'(MEM_TIMEOUT - 1));
   assign w_waitDone   = mem_ack || w_timeoutHit;

   // Cycles where the pipeline moves; a timed-out access counts as complete.
   assign w_advance = ((r_state == ST_RUN)  && !w_stall && !debug_en) ||
                      ((r_state == ST_WAIT) && w_waitDone) ||
                      ((r_state == ST_HALT) && w_stepRise && !w_stall);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_RESET;
      else
         r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      unique case (r_state)
         ST_RESET: if (r_cnt == 8'(RST_CYCLES - 1)) w_nextState = ST_RUN;
         ST_RUN: begin
            if (w_stall)
               w_nextState = ST_WAIT;
            else if (debug_en)
               w_nextState = ST_HALT;
         end
         ST_WAIT: if (w_waitDone) w_nextState = ST_RUN;
         ST_HALT: begin
            if (w_stepRise && w_stall)
               w_nextState = ST_WAIT;
            else if (!debug_en)
               w_nextState = ST_RUN;
         end
         default: w_nextState = ST_RESET;
      endcase
   end

   // Bit order of both vectors is {if, id, exe, mem, wb}.
   always_comb begin
      w_rstVec = 5'b00000;
      w_enVec  = 5'b00000;
      if (r_state == ST_RESET) begin
         w_rstVec = 5'b11111;
      end else if (w_advance) begin
         w_enVec = 5'b11111;
         if (is_branch_exe || is_branch_mem)
            w_rstVec = 5'b01100;
         if (is_branch_exe && !is_branch_mem)
            w_enVec[4] = 1'b0;
      end
   end

   // One counter serves both the reset hold and the memory wait timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= 8'd0;
         r_memErr   <= 1'b0;
         r_stepPrev <= 1'b0;
      end else begin
         r_stepPrev <= debug_step;
         if (r_state == ST_RESET)
            r_cnt <= r_cnt + 8'd1;
         else if ((r_state != ST_WAIT) && (w_nextState == ST_WAIT))
            r_cnt <= 8'd0;
         else if (r_state == ST_WAIT)
            r_cnt <= r_cnt + 8'd1;
         if ((r_state == ST_WAIT) && !mem_ack && w_timeoutHit)
            r_memErr <= 1'b1;
      end
   end

   assign {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = w_rstVec;
   assign {if_en,  id_en,  exe_en,  mem_en,  wb_en}  = w_enVec;
   assign mem_err   = r_memErr;
   assign state_dbg = r_state;

   fwd_unit u_fwdA (
      .i_src_addr      (addr_rs_exe),
      .i_wb_wen_mem    (wb_wen_mem),
      .i_mem_ren_mem   (mem_ren_mem),
      .i_regw_addr_mem (regw_addr_mem),
      .i_wb_wen_wb     (wb_wen_wb),
      .i_regw_addr_wb  (regw_addr_wb),
      .o_fwd_ctrl      (exe_fwd_a_ctrl)
   );

   fwd_unit u_fwdB (
      .i_src_addr      (addr_rt_exe),
      .i_wb_wen_mem    (wb_wen_mem),
      .i_mem_ren_mem   (mem_ren_mem),
      .i_regw_addr_mem (regw_addr_mem),
      .i_wb_wen_wb     (wb_wen_wb),
      .i_regw_addr_wb  (regw_addr_wb),
      .o_fwd_ctrl      (exe_fwd_b_ctrl)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_pipe_ctrl;

   localparam int RST_CYCLES  = 2;
   localparam int MEM_TIMEOUT = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       is_branch_exe = 1'b0, is_branch_mem = 1'b0;
   logic [4:0] addr_rs_exe = '0, addr_rt_exe = '0;
   logic       wb_wen_mem = 1'b0, mem_ren_mem = 1'b0, mem_wen_mem = 1'b0;
   logic [4:0] regw_addr_mem = '0;
   logic       wb_wen_wb = 1'b0;
   logic [4:0] regw_addr_wb = '0;
   logic       mem_ack = 1'b0, debug_en = 1'b0, debug_step = 1'b0;
   logic       if_rst, id_rst, exe_rst, mem_rst, wb_rst;
   logic       if_en, id_en, exe_en, mem_en, wb_en;
   logic [1:0] exe_fwd_a_ctrl, exe_fwd_b_ctrl;
   logic       mem_err;
   logic [1:0] state_dbg;

   int checks = 0;
   int errors = 0;
   bit checkEn = 1'b0;

   // Model: edges since reset release, whether an access is outstanding, halt flag.
   int mAge = 0;
   bit mWaiting = 1'b0;
   int mWaitCnt = 0;
   bit mHalted = 1'b0;
   bit mErr = 1'b0;
   bit mPrevStep = 1'b0;

   pipe_ctrl #(.RST_CYCLES(RST_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .is_branch_exe(is_branch_exe), .is_branch_mem(is_branch_mem),
      .addr_rs_exe(addr_rs_exe), .addr_rt_exe(addr_rt_exe),
      .wb_wen_mem(wb_wen_mem), .mem_ren_mem(mem_ren_mem), .mem_wen_mem(mem_wen_mem),
      .regw_addr_mem(regw_addr_mem), .wb_wen_wb(wb_wen_wb), .regw_addr_wb(regw_addr_wb),
      .mem_ack(mem_ack), .debug_en(debug_en), .debug_step(debug_step),
      .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst), .mem_rst(mem_rst), .wb_rst(wb_rst),
      .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
      .exe_fwd_a_ctrl(exe_fwd_a_ctrl), .exe_fwd_b_ctrl(exe_fwd_b_ctrl),
      .mem_err(mem_err), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic bit mInReset();
      return !rst_n || (mAge < RST_CYCLES);
   endfunction

   function automatic bit mStall();
      return (mem_ren_mem || mem_wen_mem) && !mem_ack;
   endfunction

   function automatic bit mRise();
      return debug_step && !mPrevStep;
   endfunction

   function automatic bit mAdvance();
      if (mInReset()) return 1'b0;
      if (mWaiting)   return mem_ack || (mWaitCnt == MEM_TIMEOUT - 1);
      if (mHalted)    return mRise() && !mStall();
      return !mStall() && !debug_en;
   endfunction

   function automatic int expState();
      if (mInReset()) return 0;
      if (mWaiting)   return 2;
      if (mHalted)    return 3;
      return 1;
   endfunction

   function automatic int expEn();
      if (!mAdvance()) return 0;
      return (is_branch_exe && !is_branch_mem) ? 5'b01111 : 5'b11111;
   endfunction

   function automatic int expRst();
      if (mInReset()) return 5'b11111;
      return (mAdvance() && (is_branch_exe || is_branch_mem)) ? 5'b01100 : 5'b00000;
   endfunction

   function automatic int expFwd(input logic [4:0] a);
      if (wb_wen_mem && a == regw_addr_mem && a != 5'd0) return mem_ren_mem ? 2 : 1;
      if (wb_wen_wb && a == regw_addr_wb && a != 5'd0) return 3;
      return 0;
   endfunction

   // Advance the model on each edge using the inputs that were stable before it.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mAge = 0; mWaiting = 1'b0; mWaitCnt = 0;
         mHalted = 1'b0; mErr = 1'b0; mPrevStep = 1'b0;
      end else begin
         if (mAge < RST_CYCLES) begin
            mAge++;
         end else if (mWaiting) begin
            if (mem_ack) mWaiting = 1'b0;
            else if (mWaitCnt == MEM_TIMEOUT - 1) begin mErr = 1'b1; mWaiting = 1'b0; end
            else mWaitCnt++;
         end else if (mHalted) begin
            if (mRise() && mStall()) begin mWaiting = 1'b1; mWaitCnt = 0; mHalted = 1'b0; end
            else if (!debug_en) mHalted = 1'b0;
         end else begin
            if (mStall()) begin mWaiting = 1'b1; mWaitCnt = 0; end
            else if (debug_en) mHalted = 1'b1;
         end
         mPrevStep = debug_step;
      end
   end

   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("state", int'(state_dbg), expState());
         checkOutput("enables", int'({if_en, id_en, exe_en, mem_en, wb_en}), expEn());
         checkOutput("resets", int'({if_rst, id_rst, exe_rst, mem_rst, wb_rst}), expRst());
         checkOutput("fwd_a", int'(exe_fwd_a_ctrl), expFwd(addr_rs_exe));
         checkOutput("fwd_b", int'(exe_fwd_b_ctrl), expFwd(addr_rt_exe));
         checkOutput("mem_err", int'(mem_err), int'(mErr));
      end
   end

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input bit be, input bit bm, input bit mr, input bit mw,
                                input bit ack, input bit den, input bit dstep);
      is_branch_exe = be; is_branch_mem = bm;
      mem_ren_mem = mr; mem_wen_mem = mw; mem_ack = ack;
      debug_en = den; debug_step = dstep;
   endtask

   task automatic setFwd(input logic [4:0] rs, input logic [4:0] rt, input bit wm,
                         input logic [4:0] am, input bit ww, input logic [4:0] aw);
      addr_rs_exe = rs; addr_rt_exe = rt; wb_wen_mem = wm;
      regw_addr_mem = am; wb_wen_wb = ww; regw_addr_wb = aw;
   endtask

   task automatic literalPipe(input string tag, input int st, input int en, input int rs);
      checkOutput({tag, "_state"}, int'(state_dbg), st);
      checkOutput({tag, "_en"}, int'({if_en, id_en, exe_en, mem_en, wb_en}), en);
      checkOutput({tag, "_rst"}, int'({if_rst, id_rst, exe_rst, mem_rst, wb_rst}), rs);
   endtask

   initial begin
      @(posedge clk);
      checkEn = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      settle();
      literalPipe("rel0", 0, 0, 31);
      nextCycle(); settle();
      literalPipe("rel1", 0, 0, 31);
      nextCycle(); settle();
      literalPipe("rel2", 1, 31, 0);

      nextCycle(); applyStimulus(1, 0, 0, 0, 0, 0, 0); settle();
      literalPipe("br_exe", 1, 5'b01111, 5'b01100);
      nextCycle(); applyStimulus(0, 1, 0, 0, 0, 0, 0); settle();
      literalPipe("br_mem", 1, 31, 5'b01100);
      nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 0); settle();
      literalPipe("br_done", 1, 31, 0);

      nextCycle(); setFwd(5, 9, 1, 5, 1, 5); settle();
      checkOutput("fwd_alu", int'(exe_fwd_a_ctrl), 1);
      checkOutput("fwd_b_none", int'(exe_fwd_b_ctrl), 0);
      nextCycle(); applyStimulus(0, 0, 1, 0, 1, 0, 0); settle();
      checkOutput("fwd_din", int'(exe_fwd_a_ctrl), 2);
      nextCycle(); wb_wen_mem = 1'b0; settle();
      checkOutput("fwd_wb", int'(exe_fwd_a_ctrl), 3);
      nextCycle(); setFwd(0, 0, 1, 0, 1, 0); settle();
      checkOutput("fwd_zero", int'(exe_fwd_a_ctrl), 0);
      nextCycle(); setFwd(0, 0, 0, 0, 0, 0); applyStimulus(0, 0, 0, 0, 0, 0, 0); settle();

      for (int k = 0; k < 4; k++) begin
         nextCycle(); applyStimulus(0, k > 0, 1, 0, 0, 0, 0); settle();
         literalPipe("wait_frozen", (k == 0) ? 1 : 2, 0, 0);
      end
      nextCycle(); applyStimulus(0, 0, 1, 0, 1, 0, 0); settle();
      literalPipe("wait_ack", 2, 31, 0);
      nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 0); settle();
      literalPipe("wait_done", 1, 31, 0);

      for (int k = 0; k < MEM_TIMEOUT + 1; k++) begin
         nextCycle(); applyStimulus(0, 0, 1, 0, 0, 0, 0); settle();
      end
      literalPipe("tmo_last", 2, 31, 0);
      checkOutput("tmo_err_pre", int'(mem_err), 0);
      nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 0); settle();
      checkOutput("tmo_state", int'(state_dbg), 1);
      checkOutput("tmo_err", int'(mem_err), 1);

      nextCycle(); applyStimulus(0, 0, 0, 0, 0, 1, 0); settle();
      literalPipe("dbg_enter", 1, 0, 0);
      nextCycle(); settle();
      literalPipe("dbg_halt", 3, 0, 0);
      for (int k = 0; k < 3; k++) begin
         nextCycle(); applyStimulus(0, 0, 0, 0, 0, 1, 1); settle();
         literalPipe("dbg_step", 3, (k == 0) ? 31 : 0, 0);
      end
      nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 0); settle();
      literalPipe("dbg_leave", 3, 0, 0);
      nextCycle(); settle();
      literalPipe("dbg_run", 1, 31, 0);
      checkOutput("err_sticky", int'(mem_err), 1);

      for (int c = 0; c < 800; c++) begin
         nextCycle();
         if (c % 200 == 199) rst_n = 1'b0;
         else rst_n = 1'b1;
         applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                       $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                       (c >= 300 && c < 450) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 1) == 1),
                       ($urandom_range(0, 19) == 0) ? !debug_en : debug_en,
                       $urandom_range(0, 2) == 0);
         setFwd(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
      end

      nextCycle(); rst_n = 1'b0; applyStimulus(0, 0, 0, 0, 0, 0, 0); settle();
      literalPipe("final_rst", 0, 0, 31);
      checkOutput("final_err", int'(mem_err), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
